// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-requester bus arbiter: FSM encoding,
// default widths and the IO window base address.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int          NUM_REQ     = 2;
    localparam int          ADDR_W_DEF  = 32;
    localparam int          DATA_W_DEF  = 32;
    localparam int          IO_W        = 16;
    localparam logic [31:0] IO_BASE_DEF = 32'hFFFF_FC00;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester, data-memory and IO signals of the arbiter bundled together.
// The arbiter uses the slave view; requesters/memory/IO use the master view.
interface bus_arbiter_if import bus_arbiter_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [DATA_W-1:0]         rdata;
    logic [NUM_REQ-1:0]        done;
    logic [ADDR_W-1:0]         bus_addr;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      io_read;
    logic                      io_write;
    logic [IO_W-1:0]           io_wdata;
    logic [IO_W-1:0]           io_rdata;
    logic                      busy;
    logic                      owner;

    modport slave (
        input  req, we, addr, wdata, mem_rdata, io_rdata,
        output rdata, done, bus_addr, mem_we, mem_wdata,
               io_read, io_write, io_wdata, busy, owner
    );

    modport master (
        output req, we, addr, wdata, mem_rdata, io_rdata,
        input  rdata, done, bus_addr, mem_we, mem_wdata,
               io_read, io_write, io_wdata, busy, owner
    );

endinterface

// File: rtl/bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not served
// last wins; a lone request always wins.
module rr_pick2 import bus_arbiter_pkg::*; (
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_owner,
    output logic               winner
);

    always_comb begin
        winner = 1'b0;
        case (req)
            2'b11:   winner = ~last_owner;
            2'b10:   winner = 1'b1;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Serialises CPU and program-loader accesses onto one address bus that is
// decoded into synchronous data memory (low) and IO space (>= IO_BASE).
module bus_arbiter import bus_arbiter_pkg::*; #(
    parameter int          ADDR_W  = ADDR_W_DEF,
    parameter int          DATA_W  = DATA_W_DEF,
    parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    bus_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);

    state_t              state_reg, state_next;
    logic                owner_reg, last_owner_reg, we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg, rdata_reg;
    logic                winner, is_io, latch;
    logic                mem_we_next, io_read_next, io_write_next;
    logic [NUM_REQ-1:0]  done_next;
    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick2 u_pick (
        .req        (bus.req),
        .last_owner (last_owner_reg),
        .winner     (winner)
    );

    assign latch = (state_reg == IDLE) && (|bus.req);
    assign is_io = (addr_reg >= IO_BASE_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Strobes decode straight from state so reset drops them without a clock.
    always_comb begin
        state_next    = state_reg;
        mem_we_next   = 1'b0;
        io_read_next  = 1'b0;
        io_write_next = 1'b0;
        done_next     = '0;
        case (state_reg)
            IDLE: begin
                if (|bus.req) state_next = ISSUE;
            end
            ISSUE: begin
                if (we_reg) begin
                    mem_we_next   = ~is_io;
                    io_write_next = is_io;
                    state_next    = RESP;
                end else begin
                    io_read_next  = is_io;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                io_read_next = is_io;
                state_next   = RESP;
            end
            RESP: begin
                done_next[owner_reg] = 1'b1;
                state_next           = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
        end else begin
            if (latch) begin
                owner_reg <= winner;
                addr_reg  <= addr_arr[winner];
                we_reg    <= bus.we[winner];
                wdata_reg <= wdata_arr[winner];
            end
            // Only reads pass through WAIT, so writes never disturb rdata.
            if (state_reg == WAIT) begin
                rdata_reg <= is_io ? {{(DATA_W-IO_W){1'b0}}, bus.io_rdata} : bus.mem_rdata;
            end
            if (state_reg == RESP) last_owner_reg <= owner_reg;
        end
    end

    assign bus.bus_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.io_wdata  = wdata_reg[IO_W-1:0];
    assign bus.mem_we    = mem_we_next;
    assign bus.io_read   = io_read_next;
    assign bus.io_write  = io_write_next;
    assign bus.done      = done_next;
    assign bus.rdata     = rdata_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.owner     = owner_reg;

endmodule
